// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// Data wins by default; a starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_arbiter #(
  parameter int WORD_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              merr
);

  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;
  typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;

  typedef struct packed {
    logic              ren;
    logic              wen;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] store;
  } ram_req_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t    state, next_state;
  logic [3:0] count, next_count;
  logic      merr_q, next_merr;
  ram_req_t  req;
  ramstate_t rs;
  logic      d_req;
  logic      i_starved;

  assign rs        = ramstate_t'(ramstate);
  assign d_req     = dREN | dWEN;
  assign i_starved = iREN && (count == LIMIT);

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state  <= IDLE;
      count  <= '0;
      merr_q <= 1'b0;
    end else begin
      state  <= next_state;
      count  <= next_count;
      merr_q <= next_merr;
    end
  end

  always_comb begin
    next_state = state;
    next_count = count;
    next_merr  = 1'b0;
    req        = '0;
    iwait      = iREN;
    dwait      = d_req;
    iload      = '0;
    dload      = '0;
    unique case (state)
      IDLE: begin
        // Count only grants that made a pending fetch wait.
        if (d_req && !i_starved) begin
          next_state = DGRANT;
          next_count = iREN ? count + 4'd1 : 4'd0;
        end else if (iREN) begin
          next_state = IGRANT;
          next_count = '0;
        end else begin
          next_count = '0;
        end
      end
      DGRANT: begin
        req.addr  = daddr;
        req.store = dstore;
        if (!d_req) begin
          next_state = IDLE;
        end else begin
          req.wen = dWEN;
          req.ren = dREN & ~dWEN;
          if (rs == ACCESS) begin
            dwait      = 1'b0;
            if (!dWEN) dload = ramload;
            next_state = IDLE;
          end else if (rs == ERROR) begin
            dwait      = 1'b0;
            next_merr  = 1'b1;
            next_state = IDLE;
          end
        end
      end
      IGRANT: begin
        req.addr = iaddr;
        if (!iREN) begin
          next_state = IDLE;
        end else begin
          req.ren = 1'b1;
          if (rs == ACCESS) begin
            iwait      = 1'b0;
            iload      = ramload;
            next_state = IDLE;
          end else if (rs == ERROR) begin
            iwait      = 1'b0;
            next_merr  = 1'b1;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign ramREN   = req.ren;
  assign ramWEN   = req.wen;
  assign ramaddr  = req.addr;
  assign ramstore = req.store;
  assign merr     = merr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with spec constants, then random traffic against a transaction model.
module tb_mem_arbiter;
  localparam int W     = 32;
  localparam int LIMIT = 4;

  logic         CLK = 1'b0;
  logic         nRST = 1'b1;
  logic         iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [W-1:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic [1:0]   ramstate = 2'd0;
  logic         iwait, dwait, ramREN, ramWEN, merr;
  logic [W-1:0] iload, dload, ramaddr, ramstore;

  int vectors = 0;
  int miscompares = 0;

  mem_arbiter #(.WORD_W(W), .STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .merr(merr)
  );

  always #5 CLK = ~CLK;

  // Transaction-level model: who owns the RAM, how many data grants a waiting fetch has sat through.
  int           m_owner = 0;   // 0 nobody, 1 data side, 2 fetch side
  int           m_streak = 0;
  bit           m_merr = 0;
  bit           m_end, m_fault;
  logic         e_ren, e_wen, e_iwait, e_dwait, e_merr;
  logic [W-1:0] e_addr, e_store, e_iload, e_dload;

  task automatic model_eval();
    bit dreq;
    dreq = dREN || dWEN;
    e_ren = 0; e_wen = 0; e_addr = '0; e_store = '0; e_iload = '0; e_dload = '0;
    e_iwait = iREN; e_dwait = dreq; e_merr = m_merr; m_end = 0; m_fault = 0;
    if (m_owner == 1) begin
      e_addr = daddr; e_store = dstore;
      if (!dreq) m_end = 1;
      else begin
        e_wen = dWEN; e_ren = dREN && !dWEN;
        if (ramstate >= 2) begin
          m_end = 1; e_dwait = 0; m_fault = (ramstate == 3);
          if (ramstate == 2 && !dWEN) e_dload = ramload;
        end
      end
    end else if (m_owner == 2) begin
      e_addr = iaddr;
      if (!iREN) m_end = 1;
      else begin
        e_ren = 1;
        if (ramstate >= 2) begin
          m_end = 1; e_iwait = 0; m_fault = (ramstate == 3);
          if (ramstate == 2) e_iload = ramload;
        end
      end
    end
  endtask

  task automatic model_commit();
    bit dreq;
    model_eval();
    dreq = dREN || dWEN;
    if (nRST) begin
      m_owner = 0; m_streak = 0; m_merr = 0;
    end else begin
      m_merr = m_fault;
      if (m_owner == 0) begin
        if (dreq && !(iREN && m_streak >= LIMIT)) begin
          m_owner = 1; m_streak = iREN ? m_streak + 1 : 0;
        end else begin
          if (iREN) m_owner = 2;
          m_streak = 0;
        end
      end else if (m_end) m_owner = 0;
    end
  endtask

  task automatic sample();
    @(negedge CLK);
    model_eval();
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    model_commit();
    #1;
  endtask

  task automatic quiet();
    iREN = 0; dREN = 0; dWEN = 0; ramstate = 2'd0; nRST = 0;
    next_cycle(); next_cycle();
  endtask

  task automatic pulse_reset();
    nRST = 1; next_cycle(); nRST = 0;
  endtask

  task automatic test_reset();
    nRST = 1; iREN = 1; dREN = 1; iaddr = 32'h20; daddr = 32'h10;
    for (int c = 0; c < 2; c++) begin
      next_cycle(); sample();
      vectors++; if ({ramREN, ramWEN} !== 2'b00) begin miscompares++; $display("FAIL reset_strobes: got %b want 00", {ramREN, ramWEN}); end
      vectors++; if (merr !== 1'b0) begin miscompares++; $display("FAIL reset_merr: got %b want 0", merr); end
      vectors++; if ({iwait, dwait} !== 2'b11) begin miscompares++; $display("FAIL reset_waits: got %b want 11", {iwait, dwait}); end
    end
    next_cycle(); nRST = 0;
    sample(); next_cycle();
    sample(); ramstate = 2'd2;
    #1;
    vectors++; if (!(ramREN === 1'b1 && ramaddr === 32'h10)) begin miscompares++; $display("FAIL reset_first_grant: ren %b addr %h want 1 00000010", ramREN, ramaddr); end
    vectors++; if (iwait !== 1'b1) begin miscompares++; $display("FAIL reset_iwait_held: got %b want 1", iwait); end
    next_cycle(); quiet();
  endtask

  task automatic test_single_fetch();
    pulse_reset();
    iREN = 1; iaddr = 32'h40; ramload = 32'h8C220004; ramstate = 2'd1;
    sample();
    vectors++; if (ramREN !== 1'b0) begin miscompares++; $display("FAIL fetch_idle_ren: got %b want 0", ramREN); end
    next_cycle();
    for (int c = 0; c < 2; c++) begin
      sample();
      vectors++; if (!(ramREN === 1'b1 && ramaddr === 32'h40 && iwait === 1'b1)) begin miscompares++; $display("FAIL fetch_busy: ren %b addr %h iwait %b want 1 00000040 1", ramREN, ramaddr, iwait); end
      next_cycle();
    end
    ramstate = 2'd2; sample();
    vectors++; if (!(iwait === 1'b0 && iload === 32'h8C220004)) begin miscompares++; $display("FAIL fetch_access: iwait %b iload %h want 0 8c220004", iwait, iload); end
    next_cycle(); iREN = 0; ramstate = 2'd0; sample();
    vectors++; if (!(ramREN === 1'b0 && iload === 32'h0)) begin miscompares++; $display("FAIL fetch_after: ren %b iload %h want 0 0", ramREN, iload); end
    quiet();
  endtask

  task automatic test_contention();
    pulse_reset();
    iREN = 1; iaddr = 32'h200; dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    sample(); next_cycle();
    ramstate = 2'd2; sample();
    vectors++; if (!(ramWEN === 1'b1 && ramREN === 1'b0 && ramaddr === 32'h100 && ramstore === 32'hDEADBEEF)) begin miscompares++; $display("FAIL cont_dwrite: wen %b ren %b addr %h st %h", ramWEN, ramREN, ramaddr, ramstore); end
    vectors++; if ({iwait, dwait} !== 2'b10) begin miscompares++; $display("FAIL cont_waits: got %b want 10", {iwait, dwait}); end
    next_cycle(); dWEN = 0; sample();
    vectors++; if (!({ramREN, ramWEN} === 2'b00 && iwait === 1'b1)) begin miscompares++; $display("FAIL cont_bubble: strobes %b iwait %b want 00 1", {ramREN, ramWEN}, iwait); end
    next_cycle(); sample();
    vectors++; if (!(ramREN === 1'b1 && ramaddr === 32'h200 && iwait === 1'b0)) begin miscompares++; $display("FAIL cont_fetch: ren %b addr %h iwait %b want 1 00000200 0", ramREN, ramaddr, iwait); end
    next_cycle(); quiet();
  endtask

  task automatic test_starvation();
    int dgr; bit seen;
    pulse_reset();
    iREN = 1; iaddr = 32'h300; dREN = 1; daddr = 32'h500; ramstate = 2'd2;
    for (int round = 0; round < 2; round++) begin
      dgr = 0; seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
        sample();
        if (ramREN === 1'b1 && ramaddr === 32'h500) dgr++;
        if (ramREN === 1'b1 && ramaddr === 32'h300) seen = 1;
        next_cycle();
      end
      vectors++; if (!seen) begin miscompares++; $display("FAIL starve_igrant_r%0d: got none want fetch grant within 40 cycles", round); end
      vectors++; if (dgr != LIMIT) begin miscompares++; $display("FAIL starve_count_r%0d: got %0d data grants want %0d", round, dgr, LIMIT); end
    end
    quiet();
  endtask

  task automatic test_error();
    pulse_reset();
    iREN = 1; iaddr = 32'h44; ramload = 32'h12345678;
    sample(); next_cycle();
    ramstate = 2'd3; sample();
    vectors++; if (!(iwait === 1'b0 && iload === 32'h0 && merr === 1'b0)) begin miscompares++; $display("FAIL err_cycle: iwait %b iload %h merr %b want 0 0 0", iwait, iload, merr); end
    next_cycle(); iREN = 0; ramstate = 2'd0; sample();
    vectors++; if (!(merr === 1'b1 && ramREN === 1'b0)) begin miscompares++; $display("FAIL err_pulse: merr %b ren %b want 1 0", merr, ramREN); end
    next_cycle(); sample();
    vectors++; if (merr !== 1'b0) begin miscompares++; $display("FAIL err_single: merr %b want 0", merr); end
    quiet();
  endtask

  task automatic test_abort();
    pulse_reset();
    dREN = 1; daddr = 32'h80; ramstate = 2'd1;
    sample(); next_cycle();
    sample();
    vectors++; if (ramREN !== 1'b1) begin miscompares++; $display("FAIL abort_pre: ren %b want 1", ramREN); end
    next_cycle(); dREN = 0; sample();
    vectors++; if (!({ramREN, ramWEN} === 2'b00 && dwait === 1'b0)) begin miscompares++; $display("FAIL abort_drop: strobes %b dwait %b want 00 0", {ramREN, ramWEN}, dwait); end
    next_cycle(); dREN = 1; sample();
    vectors++; if (!(merr === 1'b0 && ramREN === 1'b0)) begin miscompares++; $display("FAIL abort_idle: merr %b ren %b want 0 0", merr, ramREN); end
    next_cycle(); ramstate = 2'd2; sample();
    vectors++; if (!(ramREN === 1'b1 && dwait === 1'b0)) begin miscompares++; $display("FAIL abort_regrant: ren %b dwait %b want 1 0", ramREN, dwait); end
    next_cycle(); quiet();
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    dWEN = 1; daddr = 32'h900; dstore = 32'hA5A5A5A5; ramstate = 2'd1;
    sample(); next_cycle();
    nRST = 1; sample();
    vectors++; if (ramWEN !== 1'b1) begin miscompares++; $display("FAIL rmid_grant: wen %b want 1", ramWEN); end
    next_cycle(); nRST = 0; sample();
    vectors++; if (!({ramREN, ramWEN} === 2'b00 && dwait === 1'b1)) begin miscompares++; $display("FAIL rmid_idle: strobes %b dwait %b want 00 1", {ramREN, ramWEN}, dwait); end
    next_cycle(); ramstate = 2'd2; sample();
    vectors++; if (!(ramWEN === 1'b1 && ramaddr === 32'h900)) begin miscompares++; $display("FAIL rmid_rearb: wen %b addr %h want 1 00000900", ramWEN, ramaddr); end
    next_cycle(); quiet();
  endtask

  task automatic test_random();
    pulse_reset();
    for (int c = 0; c < 600; c++) begin
      nRST     = ($urandom_range(0, 49) == 0);
      iREN     = ($urandom_range(0, 3) != 0);
      dREN     = ($urandom_range(0, 2) == 0);
      dWEN     = ($urandom_range(0, 3) == 0);
      iaddr    = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      ramstate = 2'($urandom_range(0, 3));
      sample();
      vectors++; if ({ramREN, ramWEN} !== {e_ren, e_wen}) begin miscompares++; $display("FAIL rnd_strobes c%0d: got %b want %b", c, {ramREN, ramWEN}, {e_ren, e_wen}); end
      vectors++; if (ramaddr !== e_addr) begin miscompares++; $display("FAIL rnd_addr c%0d: got %h want %h", c, ramaddr, e_addr); end
      vectors++; if (ramstore !== e_store) begin miscompares++; $display("FAIL rnd_store c%0d: got %h want %h", c, ramstore, e_store); end
      vectors++; if ({iwait, dwait} !== {e_iwait, e_dwait}) begin miscompares++; $display("FAIL rnd_waits c%0d: got %b want %b", c, {iwait, dwait}, {e_iwait, e_dwait}); end
      vectors++; if (iload !== e_iload) begin miscompares++; $display("FAIL rnd_iload c%0d: got %h want %h", c, iload, e_iload); end
      vectors++; if (dload !== e_dload) begin miscompares++; $display("FAIL rnd_dload c%0d: got %h want %h", c, dload, e_dload); end
      vectors++; if (merr !== e_merr) begin miscompares++; $display("FAIL rnd_merr c%0d: got %b want %b", c, merr, e_merr); end
      next_cycle();
    end
    quiet();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_starvation();
    test_error();
    test_abort();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
